uart_tx_feeder: RTL

Feeds the UART transmit path from the TX-domain read side of the asynchronous TX FIFO. Pops one byte whenever the FIFO is non-empty and the transmitter is free. Presents the byte on `TX_P_DATA` with a one-cycle `TX_DATA_VALID` pulse, then tracks `BUSY` from the UART TX FSM to detect acceptance and frame completion. Enforces an inter-frame gap and re-issues the pulse if the transmitter never acknowledges.

---
 rtl/uart_tx_feeder_pkg.sv | 18 +
 rtl/uart_tx_feeder_timer.sv | 29 ++
 rtl/uart_tx_feeder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and constants for the UART TX feeder: FSM state encoding,
// default timing parameters and the width of the shared timeout/gap timer.
package uart_tx_feeder_pkg;

    localparam int TMR_W           = 8;
    localparam int GAP_CYCLES_DEF  = 2;
    localparam int ACK_TIMEOUT_DEF = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        PRESENT   = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_timer.sv
// Loadable down-counter shared by the acknowledge timeout and the inter-frame gap.
// Saturates at zero so a stray decrement can never wrap it back to full scale.
module uart_tx_feeder_timer
    import uart_tx_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_value,
    input  logic             dec,
    output logic [TMR_W-1:0] value,
    output logic             zero
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - TMR_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Pops bytes from the TX FIFO read side and hands them to the UART TX FSM,
// tracking BUSY for acceptance, re-pulsing on timeout and enforcing an inter-frame gap.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  BUSY,
    output logic                  RD_INC,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic [7:0]            FRAMES_SENT,
    output logic                  RETRY_SEEN
);

    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES);

    feeder_state_e    state;
    feeder_state_e    state_next;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_value;
    logic             tmr_dec;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             ack_timeout;
    logic             frame_done;
    logic             gap_done;

    uart_tx_feeder_timer u_timer (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

    // Acknowledge has priority: BUSY high in the expiry cycle is not a timeout.
    assign ack_timeout = (state == WAIT_ACK) && !BUSY && tmr_zero;
    assign frame_done  = (state == WAIT_DONE) && !BUSY;
    assign gap_done    = (tmr_value == '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (!FIFO_EMPTY) state_next = FETCH;
            FETCH:     state_next = PRESENT;
            PRESENT:   state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (BUSY) begin
                    state_next = WAIT_DONE;
                end else if (tmr_zero) begin
                    state_next = PRESENT;
                end
            end
            WAIT_DONE: if (!BUSY) state_next = GAP;
            GAP:       if (gap_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        RD_INC         = 1'b0;
        TX_DATA_VALID  = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_dec        = 1'b0;
        unique case (state)
            FETCH: RD_INC = 1'b1;
            PRESENT: begin
                TX_DATA_VALID  = 1'b1;
                tmr_load       = 1'b1;
                tmr_load_value = ACK_LOAD;
            end
            WAIT_ACK: tmr_dec = !BUSY && !tmr_zero;
            WAIT_DONE: begin
                if (!BUSY) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = GAP_LOAD;
                end
            end
            GAP:     tmr_dec = !gap_done;
            default: ;
        endcase
    end

    // The byte register is cleared on reset so a popped-but-unsent byte is dropped.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            TX_P_DATA   <= '0;
            FRAMES_SENT <= '0;
            RETRY_SEEN  <= 1'b0;
        end else begin
            if (state == FETCH) begin
                TX_P_DATA <= RD_DATA;
            end
            if (frame_done) begin
                FRAMES_SENT <= FRAMES_SENT + 8'd1;
            end
            if (ack_timeout) begin
                RETRY_SEEN <= 1'b1;
            end
        end
    end

endmodule
